// File: rtl/audio_pkg.sv
// Shared audio definitions: channel indices and the default-width sample type.
package audio_pkg;

  localparam int SAMPLE_WIDTH_DEFAULT = 16;
  localparam int CH_LEFT  = 0;
  localparam int CH_RIGHT = 1;

  typedef logic [SAMPLE_WIDTH_DEFAULT-1:0] sample_t;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S timing generator: clk divider for BCLK, frame position counter, LRCK,
// and the bit-boundary / sample-point event strobes used by the data path.
module i2s_clkgen #(
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  output logic                            bit_edge,
  output logic                            bit_last,
  output logic                            sample_edge,
  output logic [$clog2(2*SLOT_WIDTH)-1:0] p,
  output logic                            aud_bclk,
  output logic                            aud_lrck
);

  localparam int P_W = $clog2(2*SLOT_WIDTH);
  localparam int D_W = $clog2(BCLK_DIV);
  localparam logic [D_W-1:0] DIV_LAST = D_W'(BCLK_DIV - 1);
  localparam logic [D_W-1:0] DIV_HALF = D_W'(BCLK_DIV / 2);
  localparam logic [P_W-1:0] P_LAST   = P_W'(2*SLOT_WIDTH - 1);
  localparam logic [P_W-1:0] SLOT_P   = P_W'(SLOT_WIDTH);

  logic [D_W-1:0] div_cnt_reg, div_next;
  logic [P_W-1:0] p_reg, p_next;

  always_comb begin
    div_next = div_cnt_reg + 1'b1;
    p_next   = p_reg;
    if (div_cnt_reg == DIV_LAST) begin
      div_next = '0;
      p_next   = (p_reg == P_LAST) ? '0 : p_reg + 1'b1;
    end
  end

  // BCLK/LRCK are registered from the next-state values so they line up with p.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_cnt_reg <= '0;
      p_reg       <= '0;
      aud_bclk    <= 1'b0;
      aud_lrck    <= 1'b0;
    end else begin
      div_cnt_reg <= div_next;
      p_reg       <= p_next;
      aud_bclk    <= (div_next >= DIV_HALF);
      aud_lrck    <= (p_next >= SLOT_P);
    end
  end

  assign p           = p_reg;
  assign bit_edge    = enable && (div_cnt_reg == '0);
  assign bit_last    = enable && (div_cnt_reg == DIV_LAST);
  assign sample_edge = enable && (div_cnt_reg == DIV_HALF);

endmodule

// File: rtl/i2s_codec_if.sv
// Stereo I2S master: serialises the DAC pair, deserialises the ADC pair, raises
// per-channel req/end strobes. Optional AUDIO_LOOPBACK_EN adds a loopback input.
module i2s_codec_if import audio_pkg::*; #(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT,
  parameter int SLOT_WIDTH   = 32,
  parameter int BCLK_DIV     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] tx_left,
  input  logic [SAMPLE_WIDTH-1:0] tx_right,
  output logic [1:0]              sample_req,
  output logic [SAMPLE_WIDTH-1:0] rx_left,
  output logic [SAMPLE_WIDTH-1:0] rx_right,
  output logic [1:0]              sample_end,
  output logic                    aud_bclk,
  output logic                    aud_lrck,
  input  logic                    aud_adcdat,
  output logic                    aud_dacdat
`ifdef AUDIO_LOOPBACK_EN
  ,
  input  logic                    loopback
`endif
);

  localparam int P_W = $clog2(2*SLOT_WIDTH);
  localparam logic [P_W-1:0] SLOT_P = P_W'(SLOT_WIDTH);
  localparam logic [P_W-1:0] SW_K   = P_W'(SAMPLE_WIDTH);

  generate
    if (SLOT_WIDTH < SAMPLE_WIDTH + 1 || SAMPLE_WIDTH < 2) begin : g_bad_slot
      $error("i2s_codec_if: SLOT_WIDTH must be >= SAMPLE_WIDTH+1");
    end
    if (BCLK_DIV < 2 || (BCLK_DIV % 2) != 0) begin : g_bad_div
      $error("i2s_codec_if: BCLK_DIV must be even and >= 2");
    end
  endgenerate

  logic                    bit_edge, bit_last, sample_edge;
  logic [P_W-1:0]          p, k;
  logic                    slot, in_word, rx_bit;
  logic [SAMPLE_WIDTH-1:0] tx_shift_reg, rx_shift_reg, rx_word;
  logic [SAMPLE_WIDTH-1:0] rx_left_reg, rx_right_reg;
  logic [1:0]              sample_req_reg, sample_end_reg;
  logic                    dacdat_reg;

  i2s_clkgen #(
    .SLOT_WIDTH (SLOT_WIDTH),
    .BCLK_DIV   (BCLK_DIV)
  ) u_clkgen (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .bit_edge    (bit_edge),
    .bit_last    (bit_last),
    .sample_edge (sample_edge),
    .p           (p),
    .aud_bclk    (aud_bclk),
    .aud_lrck    (aud_lrck)
  );

  assign slot    = (p >= SLOT_P);
  assign k       = slot ? p - SLOT_P : p;
  assign in_word = (k != '0) && (k <= SW_K);

`ifdef AUDIO_LOOPBACK_EN
  assign rx_bit = loopback ? dacdat_reg : aud_adcdat;
`else
  assign rx_bit = aud_adcdat;
`endif

  assign rx_word = {rx_shift_reg[SAMPLE_WIDTH-2:0], rx_bit};

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift_reg   <= '0;
      rx_shift_reg   <= '0;
      rx_left_reg    <= '0;
      rx_right_reg   <= '0;
      sample_req_reg <= '0;
      sample_end_reg <= '0;
      dacdat_reg     <= 1'b0;
    end else begin
      sample_req_reg <= '0;
      sample_end_reg <= '0;
      if (!enable) dacdat_reg <= 1'b0;
      // Each load requests the other channel, a full slot ahead of its own load.
      if (bit_edge && p == '0) begin
        tx_shift_reg               <= tx_left;
        sample_req_reg[CH_RIGHT]   <= 1'b1;
      end
      if (bit_edge && p == SLOT_P) begin
        tx_shift_reg               <= tx_right;
        sample_req_reg[CH_LEFT]    <= 1'b1;
      end
      // The bit for slot position k+1 is presented at the boundary ending position k.
      if (bit_last) begin
        if (k < SW_K) begin
          dacdat_reg   <= tx_shift_reg[SAMPLE_WIDTH-1];
          tx_shift_reg <= tx_shift_reg << 1;
        end else begin
          dacdat_reg   <= 1'b0;
        end
      end
      if (sample_edge && in_word) begin
        rx_shift_reg <= rx_word;
        if (k == SW_K) begin
          if (slot) begin
            rx_right_reg             <= rx_word;
            sample_end_reg[CH_RIGHT] <= 1'b1;
          end else begin
            rx_left_reg              <= rx_word;
            sample_end_reg[CH_LEFT]  <= 1'b1;
          end
        end
      end
    end
  end

  assign sample_req = sample_req_reg;
  assign sample_end = sample_end_reg;
  assign rx_left    = rx_left_reg;
  assign rx_right   = rx_right_reg;
  assign aud_dacdat = dacdat_reg;

endmodule

// File: tb/tb_i2s_codec_if.sv
// Directed bench for i2s_codec_if at default parameters; expected frame timing is
// computed from the cycle count, sample words are tracked in scoreboard queues.
module tb_i2s_codec_if;
  import audio_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  sample_t    tx_left = '0, tx_right = '0;
  logic [1:0] sample_req, sample_end;
  sample_t    rx_left, rx_right;
  logic       aud_bclk, aud_lrck, aud_dacdat;
  logic       aud_adcdat = 1'b0;
`ifdef AUDIO_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  always #5 clk = ~clk;

  i2s_codec_if dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .tx_left    (tx_left),
    .tx_right   (tx_right),
    .sample_req (sample_req),
    .rx_left    (rx_left),
    .rx_right   (rx_right),
    .sample_end (sample_end),
    .aud_bclk   (aud_bclk),
    .aud_lrck   (aud_lrck),
    .aud_adcdat (aud_adcdat),
    .aud_dacdat (aud_dacdat)
`ifdef AUDIO_LOOPBACK_EN
    ,
    .loopback   (loopback)
`endif
  );

  int      checks = 0;
  int      failures = 0;
  int      m = 0;
  sample_t rxq_l[$], rxq_r[$], dacq_l[$], dacq_r[$];
  sample_t last_l = '0, last_r = '0;
  sample_t cap = '0;
  bit      adc_force = 1'b0;
  logic    prev_bclk = 1'b0;
  int      n_req0 = 0, n_req1 = 0, n_end0 = 0, n_end1 = 0;
  int      n_bclk_rise = 0, n_lrck_hi = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {bclk, lrck, dacdat, req[1:0], end[1:0]} for frame cycle mm, from the frame timing rules.
  function automatic logic [6:0] exp_vec(input int mm, input sample_t txl, input sample_t txr);
    int c, d, pp, kk;
    logic sl, dac;
    sample_t w;
    c  = mm % 256;
    d  = c % 4;
    pp = c / 4;
    kk = pp % 32;
    sl = (pp >= 32);
    w  = sl ? txr : txl;
    dac = (kk >= 1 && kk <= 16) ? w[16-kk] : 1'b0;
    return {d >= 2, sl, dac, (d == 1 && pp == 0), (d == 1 && pp == 32),
            (d == 3 && pp == 48), (d == 3 && pp == 16)};
  endfunction

  function automatic logic [6:0] obs_vec();
    return {aud_bclk, aud_lrck, aud_dacdat, sample_req, sample_end};
  endfunction

  task automatic cycle(input sample_t txl, input sample_t txr, input sample_t adcl, input sample_t adcr);
    int c, pp, kk;
    sample_t w;
    c  = m % 256;
    pp = c / 4;
    kk = pp % 32;
    w  = (pp >= 32) ? adcr : adcl;
    tx_left  = txl;
    tx_right = txr;
    if (adc_force) aud_adcdat = 1'b1;
    else if (kk >= 1 && kk <= 16) aud_adcdat = w[16-kk];
    else aud_adcdat = 1'($urandom_range(0, 1));
    if (c == 0)   dacq_l.push_back(txl);
    if (c == 128) dacq_r.push_back(txr);
    if (c == 66)  rxq_l.push_back(adcl);
    if (c == 194) rxq_r.push_back(adcr);

    @(posedge clk);
    #1;
    m++;
    c  = m % 256;
    pp = c / 4;
    kk = pp % 32;
    check($sformatf("vec c=%0d", c), 32'(obs_vec()), 32'(exp_vec(m, txl, txr)));

    if (aud_bclk && !prev_bclk) n_bclk_rise++;
    prev_bclk = aud_bclk;
    if (aud_lrck) n_lrck_hi++;
    if (sample_req[0]) n_req0++;
    if (sample_req[1]) n_req1++;
    if (sample_end[0]) n_end0++;
    if (sample_end[1]) n_end1++;

    if (sample_end[0]) begin
      check("rxq_l_nonempty", 32'(rxq_l.size() != 0), 32'd1);
      if (rxq_l.size() != 0) begin
        last_l = rxq_l.pop_front();
        check("rx_left", 32'(rx_left), 32'(last_l));
      end
    end
    if (sample_end[1]) begin
      check("rxq_r_nonempty", 32'(rxq_r.size() != 0), 32'd1);
      if (rxq_r.size() != 0) begin
        last_r = rxq_r.pop_front();
        check("rx_right", 32'(rx_right), 32'(last_r));
      end
    end

    if ((c % 4) == 2 && kk >= 1 && kk <= 16) begin
      cap = {cap[14:0], aud_dacdat};
      if (kk == 16) begin
        if (pp >= 32) begin
          check("dacq_r_nonempty", 32'(dacq_r.size() != 0), 32'd1);
          if (dacq_r.size() != 0) check("dac_right_word", 32'(cap), 32'(dacq_r.pop_front()));
        end else begin
          check("dacq_l_nonempty", 32'(dacq_l.size() != 0), 32'd1);
          if (dacq_l.size() != 0) check("dac_left_word", 32'(cap), 32'(dacq_l.pop_front()));
        end
      end
    end
  endtask

  task automatic run_frame(input sample_t txl, input sample_t txr, input sample_t adcl,
                           input sample_t adcr, input int n);
    for (int i = 0; i < n; i++) cycle(txl, txr, adcl, adcr);
  endtask

  task automatic flush();
    rxq_l.delete();
    rxq_r.delete();
    dacq_l.delete();
    dacq_r.delete();
  endtask

  task automatic clear_counts();
    n_req0 = 0; n_req1 = 0; n_end0 = 0; n_end1 = 0;
    n_bclk_rise = 0; n_lrck_hi = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sample_t tl[4];
    sample_t tr[4];
    sample_t al[4];
    sample_t ar[4];
    tl = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001};
    tr = '{16'h0000, 16'hC001, 16'h1357, 16'hFFFE};
    al = '{16'hFFFF, 16'h0000, 16'h8000, 16'h2468};
    ar = '{16'h7FFF, 16'hAAAA, 16'h0001, 16'h5555};

    // Reset with enable already high
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(obs_vec()), 32'd0);
    check("reset_rx_left", 32'(rx_left), 32'd0);
    check("reset_rx_right", 32'(rx_right), 32'd0);

    // First frame: A5C3 on the left DAC, 8001 on the right ADC
    reset = 1'b0;
    m = 0;
    clear_counts();
    run_frame(16'hA5C3, 16'h0F0F, 16'h5A5A, 16'h8001, 256);
    check("bclk_rises_per_frame", 32'(n_bclk_rise), 32'd64);
    check("lrck_high_per_frame", 32'(n_lrck_hi), 32'd128);
    check("rx_right_8001", 32'(rx_right), 32'h8001);
    check("end1_first_frame", 32'(n_end1), 32'd1);
    check("end0_first_frame", 32'(n_end0), 32'd1);

    // Four frames of boundary values, strobe counting
    clear_counts();
    for (int f = 0; f < 4; f++) run_frame(tl[f], tr[f], al[f], ar[f], 256);
    check("req0_count", 32'(n_req0), 32'd4);
    check("req1_count", 32'(n_req1), 32'd4);
    check("end0_count", 32'(n_end0), 32'd4);
    check("end1_count", 32'(n_end1), 32'd4);

    // Reset in the right slot at p=40
    run_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 160);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midframe_reset_outputs", 32'(obs_vec()), 32'd0);
    check("midframe_reset_rx_left", 32'(rx_left), 32'd0);
    check("midframe_reset_rx_right", 32'(rx_right), 32'd0);
    flush();
    reset = 1'b0;
    m = 0;
    run_frame(16'h0FF0, 16'hF00F, 16'h9876, 16'h6789, 256);

    // Enable dropped mid-frame, then restarted
    run_frame(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 100);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("disable_outputs", 32'(obs_vec()), 32'd0);
    check("disable_rx_left_hold", 32'(rx_left), 32'(last_l));
    check("disable_rx_right_hold", 32'(rx_right), 32'(last_r));
    repeat (5) @(posedge clk);
    #1;
    check("disabled_outputs_stay", 32'(obs_vec()), 32'd0);
    check("disabled_rx_left_stay", 32'(rx_left), 32'hCAFE);
    flush();
    enable = 1'b1;
    m = 0;
    run_frame(16'h4321, 16'h8765, 16'h0F1E, 16'hE1F0, 256);

`ifdef AUDIO_LOOPBACK_EN
    // Loopback: ADC pin held high, RX must follow the DAC words instead
    loopback  = 1'b1;
    adc_force = 1'b1;
    run_frame(16'h1234, 16'hABCD, 16'h1234, 16'hABCD, 256);
    check("loopback_rx_left", 32'(rx_left), 32'h1234);
    loopback  = 1'b0;
    adc_force = 1'b0;
`endif

    check("scoreboard_drained",
          32'(rxq_l.size() + rxq_r.size() + dacq_l.size() + dacq_r.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
